// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character LCD read and write paths:
// register-select codes, phase state encoding and ns-to-cycle conversion.
package lcd_pkg;

   // Register-select codes driven on LCD_RS
   localparam logic RS_INSTR = 1'b0;   // busy flag / address counter, instructions
   localparam logic RS_DATA  = 1'b1;   // display / character data RAM

   // Bus-cycle phase state encoding
   localparam int         STATE_W    = 3;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETUP   = 3'd1;
   localparam logic [2:0] ST_EN_HI   = 3'd2;
   localparam logic [2:0] ST_HOLD    = 3'd3;
   localparam logic [2:0] ST_RECOVER = 3'd4;

   // Width of the phase timer and of the busy-poll counter
   localparam int TMR_W = 16;

   // Round a time in ns up to a whole number of clock cycles
   function automatic int ns_to_cyc(input int ns, input int clk_mhz);
      return (ns * clk_mhz + 999) / 1000;
   endfunction

   // A phase can never be shorter than one cycle
   function automatic int at_least_one(input int cyc);
      return (cyc < 1) ? 1 : cyc;
   endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times one bus-cycle phase. The owner loads
// (phase length - 1) on entry to a phase; zero is high in the last cycle
// of that phase. The counter parks at zero between phases.
module lcd_phase_timer
   import lcd_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_r;

   // Reload on phase entry, otherwise count down and stop at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != {W{1'b0}}) begin
         cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/lcd_status_reader.sv
// Read-side engine for the 8-bit HD44780 LCD port. Runs one LCD read
// cycle (RW = 1) per accepted request, returning either the busy flag and
// address counter (rs_sel = 0) or a data-RAM byte (rs_sel = 1).
// Optional feature macro: LCD_BUSY_POLL_EN -- when defined, an RS = 0 read
// repeats while the busy flag reads 1, up to MAX_POLLS reads, and flags
// timeout if the limit is reached. Undefined: exactly one read per request.
module lcd_status_reader
   import lcd_pkg::*;
#(
   parameter int CLK_MHZ   = 50,
   parameter int T_AS_NS   = 60,
   parameter int T_PWEH_NS = 460,
   parameter int T_H_NS    = 20,
   parameter int T_CYC_NS  = 1000,
   parameter int MAX_POLLS = 255
) (
   input  logic       clock_50,
   input  logic       reset_n,
   input  logic       req,
   input  logic       rs_sel,
   input  logic [7:0] lcd_data_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       busy_flag,
   output logic [6:0] addr_cnt,
   output logic       timeout,
   output logic       bus_own,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN
);

   // Phase lengths in clock cycles
   localparam int SETUP_CYC = at_least_one(ns_to_cyc(T_AS_NS,   CLK_MHZ));
   localparam int EN_CYC    = at_least_one(ns_to_cyc(T_PWEH_NS, CLK_MHZ));
   localparam int HOLD_CYC  = at_least_one(ns_to_cyc(T_H_NS,    CLK_MHZ));
   localparam int CYCLE_CYC = ns_to_cyc(T_CYC_NS, CLK_MHZ);
   localparam int REC_CYC   = at_least_one(CYCLE_CYC - (SETUP_CYC + EN_CYC + HOLD_CYC));

   // Timer reload values: the timer reaches zero in the last cycle of a phase
   localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
   localparam logic [TMR_W-1:0] EN_LD    = TMR_W'(EN_CYC - 1);
   localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYC - 1);
   localparam logic [TMR_W-1:0] REC_LD   = TMR_W'(REC_CYC - 1);

   // Busy-poll limit, never below one read
   localparam logic [TMR_W-1:0] POLL_MAX = TMR_W'(at_least_one(MAX_POLLS));

`ifdef LCD_BUSY_POLL_EN
   localparam logic POLL_EN = 1'b1;
`else
   localparam logic POLL_EN = 1'b0;
`endif

   logic [STATE_W-1:0] state_r;
   logic [STATE_W-1:0] state_nx_s;
   logic               tmr_load_s;
   logic [TMR_W-1:0]   tmr_val_s;
   logic               tmr_zero_s;
   logic               repeat_s;
   logic [TMR_W-1:0]   reads_s;

   logic               lcd_rs_r;
   logic               lcd_rw_r;
   logic               lcd_en_r;
   logic               bus_own_r;
   logic               busy_r;
   logic               done_r;
   logic [7:0]         cap_r;
   logic [7:0]         rd_data_r;
   logic               busy_flag_r;
   logic [6:0]         addr_cnt_r;
   logic               timeout_r;
   logic [TMR_W-1:0]   poll_cnt_r;

   lcd_phase_timer #(
      .W        (TMR_W)
   ) u_timer (
      .clk      (clock_50),
      .rst_n    (reset_n),
      .load     (tmr_load_s),
      .load_val (tmr_val_s),
      .zero     (tmr_zero_s)
   );

   // Another read follows only for a BF/AC read that saw BF = 1 and has
   // not yet used up its poll budget; always false without the poll feature.
   always_comb begin
      reads_s  = poll_cnt_r + {{(TMR_W-1){1'b0}}, 1'b1};
      repeat_s = POLL_EN && (lcd_rs_r == RS_INSTR) && cap_r[7] && (reads_s < POLL_MAX);
   end

   // Phase sequencing and timer reload on every phase entry.
   always_comb begin
      state_nx_s = state_r;
      tmr_load_s = 1'b0;
      tmr_val_s  = {TMR_W{1'b0}};
      case (state_r)
         ST_IDLE: begin
            // A request in the done cycle is dropped: IDLE really starts next cycle
            if (req && !done_r) begin
               state_nx_s = ST_SETUP;
               tmr_load_s = 1'b1;
               tmr_val_s  = SETUP_LD;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (tmr_zero_s) begin
               state_nx_s = ST_EN_HI;
               tmr_load_s = 1'b1;
               tmr_val_s  = EN_LD;
            end else begin
               state_nx_s = ST_SETUP;
            end
         end
         ST_EN_HI: begin
            if (tmr_zero_s) begin
               state_nx_s = ST_HOLD;
               tmr_load_s = 1'b1;
               tmr_val_s  = HOLD_LD;
            end else begin
               state_nx_s = ST_EN_HI;
            end
         end
         ST_HOLD: begin
            if (tmr_zero_s) begin
               state_nx_s = ST_RECOVER;
               tmr_load_s = 1'b1;
               tmr_val_s  = REC_LD;
            end else begin
               state_nx_s = ST_HOLD;
            end
         end
         ST_RECOVER: begin
            if (tmr_zero_s && repeat_s) begin
               state_nx_s = ST_SETUP;
               tmr_load_s = 1'b1;
               tmr_val_s  = SETUP_LD;
            end else if (tmr_zero_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_RECOVER;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Registered pin drive, capture and result update at each phase boundary.
   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         lcd_rs_r    <= 1'b0;
         lcd_rw_r    <= 1'b0;
         lcd_en_r    <= 1'b0;
         bus_own_r   <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         cap_r       <= 8'h00;
         rd_data_r   <= 8'h00;
         busy_flag_r <= 1'b0;
         addr_cnt_r  <= 7'h00;
         timeout_r   <= 1'b0;
         poll_cnt_r  <= {TMR_W{1'b0}};
      end else begin
         state_r <= state_nx_s;
         done_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req && !done_r) begin
                  lcd_rs_r   <= rs_sel;
                  lcd_rw_r   <= 1'b1;
                  bus_own_r  <= 1'b1;
                  busy_r     <= 1'b1;
                  timeout_r  <= 1'b0;
                  poll_cnt_r <= {TMR_W{1'b0}};
               end
            end
            ST_SETUP: begin
               if (tmr_zero_s) begin
                  lcd_en_r <= 1'b1;
               end
            end
            ST_EN_HI: begin
               // Sample the pad in the last EN-high cycle, data is long settled
               if (tmr_zero_s) begin
                  lcd_en_r <= 1'b0;
                  cap_r    <= lcd_data_in;
               end
            end
            ST_HOLD: begin
               if (tmr_zero_s) begin
                  lcd_rw_r  <= 1'b0;
                  bus_own_r <= 1'b0;
               end
            end
            ST_RECOVER: begin
               if (tmr_zero_s && repeat_s) begin
                  lcd_rw_r   <= 1'b1;
                  bus_own_r  <= 1'b1;
                  poll_cnt_r <= reads_s;
               end else if (tmr_zero_s) begin
                  rd_data_r <= cap_r;
                  if (lcd_rs_r == RS_INSTR) begin
                     busy_flag_r <= cap_r[7];
                     addr_cnt_r  <= cap_r[6:0];
                  end
                  // Finishing a BF/AC poll with BF still set means the limit was hit
                  timeout_r <= POLL_EN && (lcd_rs_r == RS_INSTR) && cap_r[7];
                  done_r    <= 1'b1;
                  busy_r    <= 1'b0;
               end
            end
            default: begin
               lcd_en_r  <= 1'b0;
               lcd_rw_r  <= 1'b0;
               bus_own_r <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign rd_data   = rd_data_r;
   assign busy_flag = busy_flag_r;
   assign addr_cnt  = addr_cnt_r;
   assign timeout   = timeout_r;
   assign bus_own   = bus_own_r;
   assign LCD_RS    = lcd_rs_r;
   assign LCD_RW    = lcd_rw_r;
   assign LCD_EN    = lcd_en_r;

endmodule

// File: tb/tb_lcd_status_reader.sv
// Self-checking bench for lcd_status_reader: a panel model answering reads,
// a cycle-level reference derived from the read timing rules, a protocol
// monitor and a directed sequence with literal expectations.
module tb_lcd_status_reader;

   // A read occupies 50 cycles counted from the edge that starts it:
   // RW/bus_own high in cycles 0..26, EN high in cycles 3..25.
   localparam int RD_CYC   = 50;
   localparam int EN_FIRST = 3;
   localparam int EN_LAST  = 25;
   localparam int RW_LAST  = 26;
   localparam int EN_WIDTH = 23;
   localparam int POLLS    = 4;
`ifdef LCD_BUSY_POLL_EN
   localparam bit POLL = 1'b1;
`else
   localparam bit POLL = 1'b0;
`endif

   logic       clock_50 = 1'b0;
   logic       reset_n;
   logic       req;
   logic       rs_sel;
   logic [7:0] lcd_data_in;
   logic       busy, done, busy_flag, timeout, bus_own, LCD_RS, LCD_RW, LCD_EN;
   logic [7:0] rd_data;
   logic [6:0] addr_cnt;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Panel model: answers the i-th read of a request with resp[i]
   logic [7:0] resp [0:7];
   int         resp_base = 0;
   int         en_falls  = 0;
   int         en_rises  = 0;
   int         done_cnt  = 0;

   // Reference model state
   bit         m_active = 1'b0;
   int         m_k = 0;
   int         m_n = 1;
   int         m_done_e = 0;
   logic       m_rs = 1'b0;
   logic [7:0] exp_rd = 8'h00;
   logic       exp_bf = 1'b0;
   logic [6:0] exp_ac = 7'h00;
   logic       exp_to = 1'b0;
   logic       e_busy, e_done, e_en, e_rw;

   // Monitor state
   logic       prev_en = 1'b0;
   bit         have_rise = 1'b0;
   int         last_rise = 0;
   int         en_len = 0;

   lcd_status_reader #(
      .CLK_MHZ     (50),
      .T_AS_NS     (60),
      .T_PWEH_NS   (460),
      .T_H_NS      (20),
      .T_CYC_NS    (1000),
      .MAX_POLLS   (POLLS)
   ) dut (
      .clock_50    (clock_50),
      .reset_n     (reset_n),
      .req         (req),
      .rs_sel      (rs_sel),
      .lcd_data_in (lcd_data_in),
      .busy        (busy),
      .done        (done),
      .rd_data     (rd_data),
      .busy_flag   (busy_flag),
      .addr_cnt    (addr_cnt),
      .timeout     (timeout),
      .bus_own     (bus_own),
      .LCD_RS      (LCD_RS),
      .LCD_RW      (LCD_RW),
      .LCD_EN      (LCD_EN)
   );

   always #10 clock_50 = ~clock_50;

   // Panel drives the answer only while EN is high, garbage otherwise
   assign lcd_data_in = LCD_EN ? resp[3'(en_falls - resp_base)] : 8'hE7;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: decides acceptance and read count, updates results at done.
   always @(posedge clock_50) begin
      cyc = cyc + 1;
      if (reset_n) begin
         if (m_active) begin
            if (cyc == m_done_e) begin
               exp_rd = resp[m_n-1];
               if (m_rs == 1'b0) begin
                  exp_bf = exp_rd[7];
                  exp_ac = exp_rd[6:0];
               end
               exp_to = POLL && (m_rs == 1'b0) && exp_rd[7];
            end
            if (cyc - 1 >= m_done_e) m_active = 1'b0;
         end else if (req) begin
            m_active = 1'b1;
            m_k      = cyc;
            m_rs     = rs_sel;
            exp_to   = 1'b0;
            m_n      = 1;
            if (POLL && !rs_sel) begin
               while (resp[m_n-1][7] && m_n < POLLS) m_n++;
            end
            m_done_e = cyc + RD_CYC * m_n;
         end
      end
   end

   // Compare process: every output against the reference on each falling edge.
   always @(negedge clock_50) begin
      e_busy = 1'b0;
      e_done = 1'b0;
      e_en   = 1'b0;
      e_rw   = 1'b0;
      if (m_active) begin
         e_busy = (cyc >= m_k) && (cyc < m_done_e);
         e_done = (cyc == m_done_e);
         for (int j = 0; j < m_n; j++) begin
            if (cyc >= m_k + RD_CYC*j + EN_FIRST && cyc <= m_k + RD_CYC*j + EN_LAST) e_en = 1'b1;
            if (cyc >= m_k + RD_CYC*j && cyc <= m_k + RD_CYC*j + RW_LAST) e_rw = 1'b1;
         end
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("lcd_en", LCD_EN, e_en);
      chk("lcd_rw", LCD_RW, e_rw);
      chk("bus_own", bus_own, e_rw);
      chk("rd_data", rd_data, exp_rd);
      chk("busy_flag", busy_flag, exp_bf);
      chk("addr_cnt", addr_cnt, exp_ac);
      chk("timeout", timeout, exp_to);
      if (e_rw) chk("lcd_rs", LCD_RS, m_rs);
   end

   // Protocol monitor: EN width, EN-rise spacing, ownership during EN, done count.
   always @(negedge clock_50) begin
      if (!reset_n) begin
         prev_en   = 1'b0;
         have_rise = 1'b0;
      end else begin
         if (LCD_EN && !prev_en) begin
            if (have_rise) chk("en_rise_spacing", (cyc - last_rise) >= RD_CYC, 1'b1);
            have_rise = 1'b1;
            last_rise = cyc;
            en_len    = 0;
            en_rises++;
         end
         if (LCD_EN) begin
            en_len++;
            chk("own_rw_during_en", bus_own && LCD_RW, 1'b1);
         end
         if (!LCD_EN && prev_en) begin
            chk("en_width", en_len, EN_WIDTH);
            en_falls++;
         end
         if (done) done_cnt++;
         prev_en = LCD_EN;
      end
   end

   // Start one request and wait (bounded) for done; lat = cycles from acceptance.
   task automatic issue(input logic rs, input bit hold, output int lat);
      int n;
      bit seen;
      n         = 0;
      seen      = 1'b0;
      resp_base = en_falls;
      rs_sel    = rs;
      req       = 1'b1;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge clock_50);
         n++;
         if (!hold) req = 1'b0;
         if (done) seen = 1'b1;
      end
      if (!seen) chk("done_seen", 1'b0, 1'b1);
      lat = n - 1;
      @(negedge clock_50);
      req = 1'b0;
      repeat (2) @(negedge clock_50);
   endtask

   task automatic apply_reset();
      reset_n  = 1'b0;
      m_active = 1'b0;
      exp_rd   = 8'h00;
      exp_bf   = 1'b0;
      exp_ac   = 7'h00;
      exp_to   = 1'b0;
   endtask

   initial begin
      int lat, d0, e0;
      for (int i = 0; i < 8; i++) resp[i] = 8'h00;
      req    = 1'b0;
      rs_sel = 1'b0;
      apply_reset();
      repeat (3) @(negedge clock_50);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_bus_own", bus_own, 1'b0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock_50);

      // Single BF/AC read
      resp[0] = 8'h25;
      issue(1'b0, 1'b0, lat);
      chk("bfac_latency", lat, 50);
      chk("bfac_rd_data", rd_data, 8'h25);
      chk("bfac_busy_flag", busy_flag, 1'b0);
      chk("bfac_addr_cnt", addr_cnt, 7'h25);

      // Data read leaves BF/AC alone
      resp[0] = 8'hC1;
      issue(1'b1, 1'b0, lat);
      chk("data_latency", lat, 50);
      chk("data_rd_data", rd_data, 8'hC1);
      chk("data_busy_flag", busy_flag, 1'b0);
      chk("data_addr_cnt", addr_cnt, 7'h25);

      // req held high through busy and the done cycle: one read only
      d0 = done_cnt;
      e0 = en_rises;
      resp[0] = 8'h3F;
      issue(1'b0, 1'b1, lat);
      repeat (5) @(negedge clock_50);
      chk("held_req_dones", done_cnt - d0, 1);
      chk("held_req_en_pulses", en_rises - e0, 1);
      chk("held_req_addr_cnt", addr_cnt, 7'h3F);

      // Reset in the middle of EN high
      resp_base = en_falls;
      resp[0]   = 8'hAA;
      rs_sel    = 1'b1;
      req       = 1'b1;
      @(negedge clock_50);
      req = 1'b0;
      repeat (10) @(negedge clock_50);
      chk("pre_reset_en", LCD_EN, 1'b1);
      @(posedge clock_50);
      #3;
      apply_reset();
      #1;
      chk("mid_rst_en", LCD_EN, 1'b0);
      chk("mid_rst_rw", LCD_RW, 1'b0);
      chk("mid_rst_rs", LCD_RS, 1'b0);
      chk("mid_rst_bus_own", bus_own, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_rd_data", rd_data, 8'h00);
      chk("mid_rst_addr_cnt", addr_cnt, 7'h00);
      repeat (2) @(negedge clock_50);
      reset_n = 1'b1;
      repeat (2) @(negedge clock_50);

      // Normal read after reset
      resp[0] = 8'h4B;
      issue(1'b0, 1'b0, lat);
      chk("post_rst_latency", lat, 50);
      chk("post_rst_rd_data", rd_data, 8'h4B);
      chk("post_rst_addr_cnt", addr_cnt, 7'h4B);

`ifdef LCD_BUSY_POLL_EN
      // Busy three times, then ready
      e0 = en_rises;
      resp[0] = 8'h80; resp[1] = 8'h80; resp[2] = 8'h80; resp[3] = 8'h12;
      issue(1'b0, 1'b0, lat);
      chk("poll_latency", lat, 200);
      chk("poll_en_pulses", en_rises - e0, 4);
      chk("poll_rd_data", rd_data, 8'h12);
      chk("poll_timeout", timeout, 1'b0);

      // Always busy: gives up after MAX_POLLS reads
      resp[3] = 8'h80;
      issue(1'b0, 1'b0, lat);
      chk("poll_lim_latency", lat, 200);
      chk("poll_lim_timeout", timeout, 1'b1);
      chk("poll_lim_busy_flag", busy_flag, 1'b1);

      // Next accepted request clears timeout
      resp[0] = 8'h11;
      issue(1'b1, 1'b0, lat);
      chk("poll_clr_timeout", timeout, 1'b0);
      chk("poll_clr_rd_data", rd_data, 8'h11);
`endif

      repeat (5) @(negedge clock_50);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lcd_status_reader.md
# lcd_status_reader

Read-side engine for the 8-bit HD44780 character LCD port on the DE2 board. Performs read cycles (LCD_RW = 1) to fetch the busy flag and address counter (RS = 0) or a data-RAM byte (RS = 1). It returns the byte to the CPU peripheral logic through a req/done handshake. It shares LCD_RS/LCD_RW/LCD_EN/LCD_DATA with the existing write path through a top-level mux controlled by `bus_own`.

## Interface
Parameters:
- CLK_MHZ, 50, system clock frequency in MHz
- T_AS_NS, 60, RS/RW setup time before EN rises
- T_PWEH_NS, 460, EN high pulse width (must be ≥ 360 ns data-delay time)
- T_H_NS, 20, RS/RW hold time after EN falls
- T_CYC_NS, 1000, minimum full enable cycle time
- MAX_POLLS, 255, busy-poll limit (used only with the poll feature)

Ports:
- clock_50  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  start a read; sampled only in IDLE
- rs_sel  in  1  register select, captured with req (0 = BF/AC, 1 = data RAM)
- lcd_data_in  in  8  LCD_DATA as seen from the tri-state pad
- busy  out  1  high from acceptance of req until done
- done  out  1  one-cycle pulse when rd_data is valid
- rd_data  out  8  last byte read; held until next done
- busy_flag  out  1  rd_data[7] when the last read had rs_sel = 0, else unchanged
- addr_cnt  out  7  rd_data[6:0] when the last read had rs_sel = 0, else unchanged
- timeout  out  1  poll limit reached (poll feature only; tied 0 otherwise)
- bus_own  out  1  reader owns the LCD pins; the top must tri-state LCD_DATA and select this block's LCD_RS/LCD_RW/LCD_EN
- LCD_RS  out  1  register select to the panel
- LCD_RW  out  1  1 = read
- LCD_EN  out  1  enable strobe

## Operation
- Cycle counts are ceil(ns × CLK_MHZ / 1000):
  - SETUP_CYC = 3
  - EN_CYC = 23
  - HOLD_CYC = 1
  - REC_CYC = CYCLE_CYC − (SETUP + EN + HOLD) = 50 − 27 = 23
  - If REC_CYC computes ≤ 0, it is forced to 1.
- FSM: IDLE → SETUP → EN_HI → HOLD → RECOVER → IDLE (or → SETUP when polling).
- IDLE: LCD_RW = 0, LCD_EN = 0, bus_own = 0.
  - On req = 1, capture rs_sel into LCD_RS, assert busy and bus_own, set LCD_RW = 1, and go to SETUP.
- SETUP: hold LCD_EN = 0 for SETUP_CYC cycles.
- EN_HI: LCD_EN = 1 for EN_CYC cycles.
  - lcd_data_in is registered into an internal capture register on the last EN_HI cycle, while EN is still high.
- HOLD: LCD_EN = 0 for HOLD_CYC cycles; LCD_RS and LCD_RW are unchanged.
- RECOVER: LCD_RW = 0, bus_own = 0, LCD_EN = 0 for REC_CYC cycles. This enforces T_CYC_NS before any next access from either path.
- Leaving RECOVER without a repeat:
  - Copy the capture register to rd_data.
  - Update busy_flag/addr_cnt if LCD_RS = 0.
  - Pulse done and drop busy.
- req while busy = 1 is ignored (not queued).
- req asserted in the same cycle that done pulses is ignored; IDLE is entered on the following cycle.
- Reset (any time, including mid-cycle), effective immediately:
  - state = IDLE
  - LCD_EN = 0, LCD_RW = 0, LCD_RS = 0
  - bus_own = 0, busy = 0, done = 0, timeout = 0
  - rd_data = 0x00, busy_flag = 0, addr_cnt = 0
  - poll counter = 0

## Timing
- req sampled high at edge k:
  - LCD_EN high for edges k+4 … k+26
  - capture at edge k+26
  - done high in the cycle after edge k+50; busy low in that same cycle
- Single-read latency: 50 cycles from acceptance to done.
- LCD_RW rises one setup period before EN and falls HOLD_CYC after EN falls.
- bus_own is never high while LCD_RW = 0 and EN = 1.
- LCD_EN is glitch-free; it is driven directly from a flop.

## Configuration
- LCD_BUSY_POLL_EN defined:
  - A read with rs_sel = 0 repeats (RECOVER → SETUP) while the captured bit 7 = 1.
  - It terminates with done when BF = 0, or after MAX_POLLS reads.
  - On the limit, done pulses with timeout = 1. timeout clears on the next accepted req.
  - Outputs reflect the final read.
  - Latency is N × 50 cycles for N reads.
- Undefined: every request performs exactly one read; timeout is constant 0.

## Structure
- Shared package lcd_pkg:
  - state enum (IDLE, SETUP, EN_HI, HOLD, RECOVER)
  - ns-to-cycles ceil function
  - RS_INSTR/RS_DATA constants, also to be used by the write path
- One sub-module, lcd_phase_timer: loadable down-counter with a zero flag, reloaded on each state entry.

## Test plan
- Single BF/AC read: model drives 0x25 during EN; req with rs_sel = 0.
  - done after 50 cycles, rd_data = 0x25, busy_flag = 0, addr_cnt = 0x25.
  - EN high exactly 23 cycles.
- Data read: rs_sel = 1, model drives 0xC1.
  - rd_data = 0xC1, LCD_RS = 1 throughout, busy_flag/addr_cnt unchanged.
- Protocol timing checks on every cycle:
  - RW/RS stable ≥ 3 cycles before EN rise and ≥ 1 after EN fall.
  - EN-rise to EN-rise ≥ 50 cycles.
  - bus_own low in IDLE.
- req pulses during busy and in the done cycle: exactly one done per accepted req, no extra EN pulses.
- Reset asserted mid-EN_HI: EN, RW and bus_own drop asynchronously; all outputs take reset values; the next req works normally.
- With LCD_BUSY_POLL_EN:
  - model returns 0x80 three times, then 0x12: four EN pulses, done at 200 cycles, rd_data = 0x12, timeout = 0.
  - model always 0x80 with MAX_POLLS = 4: done with timeout = 1 after 4 reads.
